alu_uart_master: RTL and testbench

//  Initiator side of the UART ALU link: drives the board-resident ALU responder from another FPGA or test fixture.

---
 rtl/alu_uart_master_pkg.sv | 27 ++
 rtl/alu_uart_master_if.sv | 21 ++
 rtl/alu_uart_timeout.sv | 26 ++
 rtl/alu_uart_master.sv | 113 +++++++++++
 tb/tb_alu_uart_master.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_uart_master_pkg.sv
// Shared definitions for the UART ALU link: FSM states, wire byte order, defaults.
// The responder side imports this same package.
package alu_uart_master_pkg;

    localparam int unsigned BUS_SIZE_DEF = 8;
    localparam int unsigned TIMEOUT_DEF  = 2_000_000;

    localparam int unsigned BYTE_OPA = 0;
    localparam int unsigned BYTE_OPB = 1;
    localparam int unsigned BYTE_OP  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_SEND_A,
        ST_SEND_B,
        ST_SEND_OP,
        ST_WAIT_RX,
        ST_DONE,
        ST_TOUT
    } state_t;

    function automatic int unsigned op_width(input int unsigned bus_size);
        return bus_size - 2;
    endfunction

endpackage

// File: rtl/alu_uart_master_if.sv
// uart_core FIFO handshake: TX push side and RX pop side.
interface alu_uart_master_if #(
    parameter int unsigned BUS_SIZE = 8
);
    logic                wr_uart;
    logic [BUS_SIZE-1:0] w_data;
    logic                tx_full;
    logic                rd_uart;
    logic [BUS_SIZE-1:0] r_data;
    logic                rx_empty;

    modport master (
        output wr_uart, w_data, rd_uart,
        input  tx_full, r_data, rx_empty
    );

    modport slave (
        input  wr_uart, w_data, rd_uart,
        output tx_full, r_data, rx_empty
    );
endinterface

// File: rtl/alu_uart_timeout.sv
// Transaction watchdog: cleared on start, counts while enabled, flags the last allowed cycle.
module alu_uart_timeout #(
    parameter int unsigned LIMIT = 2_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int unsigned TO_W = $clog2(LIMIT + 1);

    logic [TO_W-1:0] count;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            count <= '0;
        end else if (i_clear) begin
            count <= '0;
        end else if (i_enable) begin
            count <= count + 1'b1;
        end
    end

    assign o_expired = i_enable && (count == TO_W'(LIMIT - 1));
endmodule

// File: rtl/alu_uart_master.sv
// Initiator for the UART ALU link: sends opA, opB, opCode as three bytes, then
// pops a single result byte, reporting done or timeout.
module alu_uart_master
    import alu_uart_master_pkg::*;
#(
    parameter int unsigned BUS_SIZE = BUS_SIZE_DEF,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [BUS_SIZE-1:0] i_op_a,
    input  logic [BUS_SIZE-1:0] i_op_b,
    input  logic [BUS_SIZE-3:0] i_op_code,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_timeout,
    output logic [BUS_SIZE-1:0] o_result,
    alu_uart_master_if.master   uart
);
    localparam int unsigned OP_W = op_width(BUS_SIZE);

    state_t              state;
    logic [BUS_SIZE-1:0] tx_bytes [3];
    logic [OP_W-1:0]     op_code;
    logic                in_flight;
    logic                sending;
    logic                push;
    logic                pop_reply;
    logic                expired;

    assign in_flight = (state inside {[ST_FLUSH:ST_WAIT_RX]});
    assign sending   = (state inside {[ST_SEND_A:ST_SEND_OP]});
    assign push      = sending && !uart.tx_full;
    assign pop_reply = (state == ST_WAIT_RX) && !uart.rx_empty;

    assign tx_bytes[BYTE_OP] = {2'b00, op_code};

    alu_uart_timeout #(
        .LIMIT(TIMEOUT)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  ((state == ST_IDLE) && i_start),
        .i_enable (in_flight),
        .o_expired(expired)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state            <= ST_IDLE;
            tx_bytes[BYTE_OPA] <= '0;
            tx_bytes[BYTE_OPB] <= '0;
            op_code          <= '0;
            o_result         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        tx_bytes[BYTE_OPA] <= i_op_a;
                        tx_bytes[BYTE_OPB] <= i_op_b;
                        op_code            <= i_op_code;
                        state              <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (expired)             state <= ST_TOUT;
                    else if (uart.rx_empty)  state <= ST_SEND_A;
                end
                ST_SEND_A: begin
                    if (expired)   state <= ST_TOUT;
                    else if (push) state <= ST_SEND_B;
                end
                ST_SEND_B: begin
                    if (expired)   state <= ST_TOUT;
                    else if (push) state <= ST_SEND_OP;
                end
                ST_SEND_OP: begin
                    if (expired)   state <= ST_TOUT;
                    else if (push) state <= ST_WAIT_RX;
                end
                ST_WAIT_RX: begin
                    // a reply arriving on the limit cycle still counts as success
                    if (pop_reply) begin
                        o_result <= uart.r_data;
                        state    <= ST_DONE;
                    end else if (expired) begin
                        state <= ST_TOUT;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_TOUT: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        uart.w_data = '0;
        case (state)
            ST_SEND_A:  uart.w_data = tx_bytes[BYTE_OPA];
            ST_SEND_B:  uart.w_data = tx_bytes[BYTE_OPB];
            ST_SEND_OP: uart.w_data = tx_bytes[BYTE_OP];
            default:    uart.w_data = '0;
        endcase
    end

    assign uart.wr_uart = push;
    assign uart.rd_uart = ((state == ST_FLUSH) || (state == ST_WAIT_RX)) && !uart.rx_empty;
    assign o_busy       = (state != ST_IDLE);
    assign o_done       = (state == ST_DONE);
    assign o_timeout    = (state == ST_TOUT);
endmodule

// File: tb/tb_alu_uart_master.sv
// Directed bench for alu_uart_master with a behavioural uart_core FIFO pair.
module tb_alu_uart_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [5:0] op_code;
    logic       busy;
    logic       done;
    logic       tout;
    logic [7:0] result;
    logic       tx_full;

    alu_uart_master_if #(.BUS_SIZE(8)) bus ();

    alu_uart_master #(
        .BUS_SIZE(8),
        .TIMEOUT (50)
    ) dut (
        .i_clk    (clk),
        .i_reset  (rst_n),
        .i_start  (start),
        .i_op_a   (op_a),
        .i_op_b   (op_b),
        .i_op_code(op_code),
        .o_busy   (busy),
        .o_done   (done),
        .o_timeout(tout),
        .o_result (result),
        .uart     (bus)
    );

    // RX FIFO model: main process writes, pop process advances the read pointer
    logic [7:0]  rx_mem [16];
    int unsigned rx_wp = 0;
    int unsigned rx_rp = 0;
    assign bus.rx_empty = (rx_wp == rx_rp);
    assign bus.r_data   = rx_mem[rx_rp[3:0]];
    assign bus.tx_full  = tx_full;

    int unsigned cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    logic [7:0]  tx_byte [64];
    int unsigned tx_cyc  [64];
    int unsigned tx_n = 0;
    int unsigned done_n = 0;
    int unsigned tout_n = 0;
    int unsigned full_push_n = 0;
    int unsigned overlap_n = 0;
    int unsigned pop_cyc [64];
    int unsigned pop_n = 0;

    always @(negedge clk) begin
        if (bus.wr_uart) begin
            tx_byte[tx_n] = bus.w_data;
            tx_cyc[tx_n]  = cyc + 1;
            tx_n = tx_n + 1;
            if (tx_full) full_push_n = full_push_n + 1;
        end
        if (done) done_n = done_n + 1;
        if (tout) tout_n = tout_n + 1;
        if (bus.wr_uart && bus.rd_uart) overlap_n = overlap_n + 1;
    end

    always @(negedge clk) begin
        if (bus.rd_uart) begin
            pop_cyc[pop_n] = cyc + 1;
            pop_n = pop_n + 1;
            @(posedge clk);
            #1 rx_rp = rx_rp + 1;
        end
    end

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned s_cyc;
    int unsigned b0, d0, t0, p0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        op_a    = a;
        op_b    = b;
        op_code = op;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        s_cyc   = cyc;
    endtask

    task automatic rx_put(input logic [7:0] v);
        rx_mem[rx_wp[3:0]] = v;
        rx_wp = rx_wp + 1;
    endtask

    task automatic wait_tx(input int unsigned n, input string tag);
        int unsigned k = 0;
        while (tx_n < n && k < 100) begin
            tick();
            k++;
        end
        chk(tag, tx_n, n);
    endtask

    task automatic wait_idle(input string tag);
        int unsigned k = 0;
        while (busy && k < 200) begin
            tick();
            k++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        tx_full = 1'b0;
        op_a    = '0;
        op_b    = '0;
        op_code = '0;
        tick();
        tick();
        chk("reset_flags", {27'd0, busy, done, tout, bus.wr_uart, bus.rd_uart}, 32'd0);
        chk("reset_wdata", bus.w_data, 32'd0);
        chk("reset_result", result, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // basic transaction with loopback reply
        b0 = tx_n; d0 = done_n;
        do_start(8'h05, 8'h03, 6'h20);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        wait_tx(b0 + 3, "t1_tx_count");
        rx_put(8'h08);
        wait_idle("t1_idle");
        repeat (3) tick();
        chk("t1_byte0", tx_byte[b0], 32'h05);
        chk("t1_byte1", tx_byte[b0+1], 32'h03);
        chk("t1_byte2", tx_byte[b0+2], 32'h20);
        chk("t1_cyc0", tx_cyc[b0] - s_cyc, 32'd2);
        chk("t1_cyc1", tx_cyc[b0+1] - s_cyc, 32'd3);
        chk("t1_cyc2", tx_cyc[b0+2] - s_cyc, 32'd4);
        chk("t1_result", result, 32'h08);
        chk("t1_done_pulses", done_n - d0, 32'd1);

        // TX full for 10 cycles while sending opB
        b0 = tx_n;
        do_start(8'h5A, 8'h03, 6'h15);
        tick();
        tick();
        tx_full = 1'b1;
        repeat (10) @(posedge clk);
        #1 tx_full = 1'b0;
        wait_tx(b0 + 3, "t2_tx_count");
        rx_put(8'h44);
        wait_idle("t2_idle");
        chk("t2_byte0", tx_byte[b0], 32'h5A);
        chk("t2_byte1", tx_byte[b0+1], 32'h03);
        chk("t2_byte2", tx_byte[b0+2], 32'h15);
        chk("t2_cyc0", tx_cyc[b0] - s_cyc, 32'd2);
        chk("t2_cyc1", tx_cyc[b0+1] - s_cyc, 32'd13);
        chk("t2_cyc2", tx_cyc[b0+2] - s_cyc, 32'd14);
        chk("t2_push_when_full", full_push_n, 32'd0);
        chk("t2_result", result, 32'h44);

        // stale RX bytes flushed before the request goes out
        rx_put(8'hAA);
        rx_put(8'hBB);
        b0 = tx_n; p0 = pop_n;
        do_start(8'h01, 8'h02, 6'h03);
        wait_tx(b0 + 3, "t3_tx_count");
        chk("t3_flush_pops", pop_n - p0, 32'd2);
        chk("t3_pop0_cyc", pop_cyc[p0] - s_cyc, 32'd1);
        chk("t3_pop1_cyc", pop_cyc[p0+1] - s_cyc, 32'd2);
        chk("t3_first_push_cyc", tx_cyc[b0] - s_cyc, 32'd4);
        rx_put(8'h11);
        wait_idle("t3_idle");
        chk("t3_result", result, 32'h11);
        chk("t3_total_pops", pop_n - p0, 32'd3);

        // no reply: timeout on cycle 50 after start
        d0 = done_n; t0 = tout_n;
        do_start(8'h09, 8'h09, 6'h00);
        repeat (49) tick();
        chk("t4_no_tout_early", {31'd0, tout}, 32'd0);
        chk("t4_busy_waiting", {31'd0, busy}, 32'd1);
        tick();
        chk("t4_tout_at_50", {31'd0, tout}, 32'd1);
        tick();
        chk("t4_tout_one_cycle", {31'd0, tout}, 32'd0);
        chk("t4_idle_after", {31'd0, busy}, 32'd0);
        chk("t4_tout_pulses", tout_n - t0, 32'd1);
        chk("t4_no_done", done_n - d0, 32'd0);
        chk("t4_result_kept", result, 32'h11);

        // start re-pulsed while busy is ignored; operands stay latched
        b0 = tx_n; d0 = done_n;
        do_start(8'h7F, 8'h80, 6'h3F);
        op_a  = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_tx(b0 + 3, "t5_tx_count");
        start = 1'b1;
        tick();
        start = 1'b0;
        rx_put(8'hC3);
        wait_idle("t5_idle");
        repeat (5) tick();
        chk("t5_no_restart", {31'd0, busy}, 32'd0);
        chk("t5_push_total", tx_n - b0, 32'd3);
        chk("t5_byte0", tx_byte[b0], 32'h7F);
        chk("t5_byte1", tx_byte[b0+1], 32'h80);
        chk("t5_byte2", tx_byte[b0+2], 32'h3F);
        chk("t5_done_pulses", done_n - d0, 32'd1);
        chk("t5_result", result, 32'hC3);

        // asynchronous reset during SEND_B, then a clean transaction
        d0 = done_n; t0 = tout_n;
        do_start(8'hEE, 8'hDD, 6'h01);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("t6_reset_flags", {27'd0, busy, done, tout, bus.wr_uart, bus.rd_uart}, 32'd0);
        chk("t6_reset_wdata", bus.w_data, 32'd0);
        chk("t6_reset_result", result, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_no_pulses", (done_n - d0) + (tout_n - t0), 32'd0);
        b0 = tx_n; d0 = done_n;
        do_start(8'h12, 8'h34, 6'h01);
        wait_tx(b0 + 3, "t6_tx_count");
        rx_put(8'h46);
        wait_idle("t6_idle");
        chk("t6_byte0", tx_byte[b0], 32'h12);
        chk("t6_byte1", tx_byte[b0+1], 32'h34);
        chk("t6_byte2", tx_byte[b0+2], 32'h01);
        chk("t6_cyc0", tx_cyc[b0] - s_cyc, 32'd2);
        chk("t6_result", result, 32'h46);
        chk("t6_done_pulses", done_n - d0, 32'd1);

        chk("wr_rd_overlap", overlap_n, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
